// File: rtl/sprite_layer.sv
// Single 16x16 sprite layer: fetches the next bitmap row during hblank, shifts it out on the visible line.
// Optional build macro SPRITE_MIRROR_EN adds flip_h to store fetched rows bit-reversed.
module sprite_layer (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic [8:0] sprite_x,
  input  logic [8:0] sprite_y,
  input  logic [2:0] sprite_color,
  input  logic [1:0] frame,
`ifdef SPRITE_MIRROR_EN
  input  logic       flip_h,
`endif
  output logic       rom_req,
  output logic [5:0] rom_addr,
  input  logic       rom_ack,
  input  logic [15:0] rom_data,
  output logic [2:0] color,
  output logic       fetch_miss
);

  localparam int unsigned H_VISIBLE = 256;
  localparam int unsigned V_TOTAL   = 262;
  localparam int unsigned ROW_W     = 16;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  fetch_buf, fetch_buf_nxt;
  logic [ROW_W-1:0]  active, active_nxt;
  logic [CNT_W-1:0]  run_left, run_left_nxt;
  logic              req_nxt;
  logic [5:0]        addr_nxt;
  logic              miss_nxt;
  logic [2:0]        color_nxt;
  logic              load_act;
  logic [ROW_W-1:0]  load_val;
  logic [ROW_W-1:0]  shift_src;
  logic [ROW_W-1:0]  captured;
  logic [8:0]        next_line;
  logic [8:0]        row;
  logic              on_line;
  logic              visible;
  logic              run_start;
  logic              run_on;

  // Row lookup for the line after the current one
  always_comb begin
    next_line = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
    row       = next_line - sprite_y;
    on_line   = row < 9'(ROW_W);
  end

`ifdef SPRITE_MIRROR_EN
  always_comb begin
    for (int i = 0; i < int'(ROW_W); i++) begin
      captured[i] = flip_h ? rom_data[int'(ROW_W) - 1 - i] : rom_data[i];
    end
  end
`else
  assign captured = rom_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fetch sequencing; an abort also forces an empty active row for the coming line
  always_comb begin
    state_nxt     = state;
    req_nxt       = rom_req;
    addr_nxt      = rom_addr;
    fetch_buf_nxt = fetch_buf;
    miss_nxt      = 1'b0;
    load_act      = 1'b0;
    load_val      = fetch_buf;
    case (state)
      IDLE: begin
        if (hpos == 9'(H_VISIBLE)) begin
          if (on_line) begin
            addr_nxt  = {frame, row[3:0]};
            req_nxt   = 1'b1;
            state_nxt = FETCH;
          end else begin
            fetch_buf_nxt = '0;
            state_nxt     = READY;
          end
        end
      end
      FETCH: begin
        if (hpos == 9'd0) begin
          req_nxt       = 1'b0;
          fetch_buf_nxt = '0;
          miss_nxt      = 1'b1;
          load_act      = 1'b1;
          load_val      = '0;
          state_nxt     = IDLE;
        end else if (rom_ack) begin
          fetch_buf_nxt = captured;
          req_nxt       = 1'b0;
          state_nxt     = READY;
        end
      end
      READY: begin
        if (hpos == 9'd0) begin
          load_act  = 1'b1;
          load_val  = fetch_buf;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel shifter; a row loaded at hpos 0 is usable by a run starting at hpos 0
  always_comb begin
    visible      = hpos < 9'(H_VISIBLE);
    shift_src    = load_act ? load_val : active;
    run_start    = visible && (hpos == sprite_x);
    run_on       = run_start || (visible && (run_left != '0));
    color_nxt    = (run_on && shift_src[ROW_W-1]) ? sprite_color : 3'd0;
    active_nxt   = run_on ? {shift_src[ROW_W-2:0], 1'b0} : shift_src;
    run_left_nxt = '0;
    if (run_start)   run_left_nxt = CNT_W'(ROW_W - 1);
    else if (run_on) run_left_nxt = run_left - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_req    <= 1'b0;
      rom_addr   <= '0;
      fetch_buf  <= '0;
      active     <= '0;
      run_left   <= '0;
      color      <= '0;
      fetch_miss <= 1'b0;
    end else begin
      rom_req    <= req_nxt;
      rom_addr   <= addr_nxt;
      fetch_buf  <= fetch_buf_nxt;
      active     <= active_nxt;
      run_left   <= run_left_nxt;
      color      <= color_nxt;
      fetch_miss <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Bench for sprite_layer: directed vector table, reset and timeout sequences, and random sprites
// checked against a line-level pixel/fetch model.
`timescale 1ns/1ps
module tb_sprite_layer;

  localparam int H_VISIBLE = 256;
  localparam int H_TOTAL   = 341;
  localparam int V_TOTAL   = 262;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos, vpos, sprite_x, sprite_y;
  logic [2:0]  sprite_color;
  logic [1:0]  frame;
  logic        flip_h;
  logic        rom_req;
  logic [5:0]  rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [2:0]  color;
  logic        fetch_miss;

  int total = 0;
  int bad   = 0;

  // model state: row the DUT should be drawing, and whether an abort pulse is due at hpos 0
  logic [15:0] exp_row;
  bit          pend_miss;
  int          lat;
  bit          stray;
  logic [15:0] rdata;

  always #5 clk = ~clk;

  sprite_layer dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color), .frame(frame),
`ifdef SPRITE_MIRROR_EN
    .flip_h(flip_h),
`endif
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .color(color), .fetch_miss(fetch_miss)
  );

  typedef struct {
    logic [8:0]  sy;
    logic [8:0]  sx;
    logic [2:0]  col;
    logic [1:0]  frm;
    int          v;
    logic [15:0] data;
    int          lat;
    bit          stray;
    bit          on;
    logic [5:0]  addr;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[15 - i];
    return r;
  endfunction

  function automatic logic [2:0] exp_pix(input int h, input logic [15:0] r);
    int sx;
    sx = int'(sprite_x);
    if (h < H_VISIBLE && sx < H_VISIBLE && h >= sx && h < sx + 16)
      return r[15 - (h - sx)] ? sprite_color : 3'd0;
    return 3'd0;
  endfunction

  function automatic int wrap_line(input int v);
    return (v == V_TOTAL - 1) ? 0 : v + 1;
  endfunction

  // Drive one full line, act as the ROM, and compare the line against the model
  task automatic run_line(input int v, output logic [5:0] cap_addr);
    logic [2:0]  got[H_TOTAL];
    int          nl, r, req_cnt, req_hi, req_first, miss_cnt, miss_first, nmis, first;
    bit          on, acked, addr_ok;
    logic [5:0]  exp_addr;
    nl = wrap_line(v);
    r  = (nl - int'(sprite_y)) & 511;
    on = r < 16;
    acked = on && lat >= 1 && lat <= H_TOTAL - H_VISIBLE - 1;
    exp_addr = {frame, 4'(r)};
    req_cnt = 0; req_hi = 0; req_first = -1; miss_cnt = 0; miss_first = -1;
    cap_addr = '0; addr_ok = 1'b1;
    for (int h = 0; h < H_TOTAL; h++) begin
      hpos = 9'(h);
      vpos = 9'(v);
      if (h >= H_VISIBLE && rom_req) req_cnt++;
      if (h > H_VISIBLE && rom_req && req_cnt == lat) begin
        rom_ack = 1'b1; rom_data = rdata;
      end else if (stray && !rom_req && (h < 200 || h >= H_VISIBLE)) begin
        rom_ack = 1'b1; rom_data = ~rdata;
      end else begin
        rom_ack = 1'b0; rom_data = 16'h0;
      end
      @(posedge clk); #1;
      got[h] = color;
      if (rom_req) begin
        req_hi++;
        if (req_first < 0) begin req_first = h; cap_addr = rom_addr; end
        else if (rom_addr !== cap_addr) addr_ok = 1'b0;
      end
      if (fetch_miss) begin
        miss_cnt++;
        if (miss_first < 0) miss_first = h;
      end
    end
    rom_ack = 1'b0;
    nmis = 0; first = -1;
    for (int h = 0; h < H_TOTAL; h++) begin
      if (got[h] !== exp_pix(h, exp_row)) begin
        nmis++;
        if (first < 0) first = h;
      end
    end
    total++;
    if (nmis != 0) begin
      bad++;
      $display("FAIL pixels line %0d: %0d wrong, first hpos=%0d got=%0d exp=%0d",
               v, nmis, first, got[first], exp_pix(first, exp_row));
    end
    check("req_first", 32'(req_first), on ? 32'(H_VISIBLE) : 32'hFFFF_FFFF);
    check("req_cycles", 32'(req_hi), on ? (acked ? 32'(lat) : 32'(H_TOTAL - H_VISIBLE)) : 32'd0);
    if (on) check("rom_addr", {25'd0, addr_ok, cap_addr}, {25'd0, 1'b1, exp_addr});
    check("fetch_miss", {16'(miss_cnt), 16'(miss_first)},
          pend_miss ? {16'd1, 16'd0} : {16'd0, 16'hFFFF});
    pend_miss = on && !acked;
    exp_row   = acked ? (flip_h ? rev16(rdata) : rdata) : 16'h0;
  endtask

  task automatic set_sprite(input logic [8:0] sy, input logic [8:0] sx, input logic [2:0] col,
                            input logic [1:0] frm, input logic [15:0] d, input int l, input bit s);
    sprite_y = sy; sprite_x = sx; sprite_color = col; frame = frm;
    rdata = d; lat = l; stray = s;
  endtask

  initial begin
    logic [5:0] a;
    int v;
    vt[0] = '{9'd10,  9'd100, 3'd5, 2'd2, 9,   16'hF00F, 3,  1'b0, 1'b1, 6'b100000};
    vt[1] = '{9'd10,  9'd30,  3'd3, 2'd1, 24,  16'h8001, 5,  1'b0, 1'b1, 6'b011111};
    vt[2] = '{9'd0,   9'd0,   3'd6, 2'd3, 261, 16'h1234, 2,  1'b0, 1'b1, 6'b110000};
    vt[3] = '{9'd50,  9'd250, 3'd7, 2'd0, 49,  16'hFFFF, 4,  1'b1, 1'b1, 6'b000000};
    vt[4] = '{9'd100, 9'd20,  3'd2, 2'd1, 99,  16'hFFFF, 0,  1'b1, 1'b1, 6'b010000};
    vt[5] = '{9'd5,   9'd300, 3'd4, 2'd0, 7,   16'hFFFF, 1,  1'b0, 1'b1, 6'b000011};
    vt[6] = '{9'd200, 9'd128, 3'd1, 2'd2, 199, 16'hAAAA, 84, 1'b0, 1'b1, 6'b100000};
    vt[7] = '{9'd200, 9'd64,  3'd5, 2'd0, 205, 16'h5555, 85, 1'b0, 1'b1, 6'b000110};
    vt[8] = '{9'd100, 9'd10,  3'd3, 2'd2, 50,  16'hFFFF, 3,  1'b1, 1'b0, 6'b000000};

    reset = 1'b1; hpos = '0; vpos = '0; rom_ack = 1'b0; rom_data = '0; flip_h = 1'b0;
    set_sprite(9'd0, 9'd0, 3'd0, 2'd0, 16'h0, 0, 1'b0);
    exp_row = '0; pend_miss = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {20'd0, rom_req, rom_addr, color, fetch_miss}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_sprite(vt[i].sy, vt[i].sx, vt[i].col, vt[i].frm, vt[i].data, vt[i].lat, vt[i].stray);
      run_line(vt[i].v, a);
      if (vt[i].on) check($sformatf("tbl_addr%0d", i), {26'd0, a}, {26'd0, vt[i].addr});
      v = wrap_line(vt[i].v);
      run_line(v, a);
      run_line(wrap_line(v), a);
    end

    // reset held three cycles while a fetch is outstanding
    set_sprite(9'd10, 9'd60, 3'd6, 2'd1, 16'hFFFF, 0, 1'b0);
    for (int h = 0; h < H_TOTAL; h++) begin
      hpos = 9'(h); vpos = 9'd9; rom_ack = 1'b0;
      reset = (h >= 270 && h <= 272);
      @(posedge clk); #1;
      if (h == 270) check("reset_mid_fetch", {29'd0, rom_req, |color, fetch_miss}, 32'd0);
    end
    reset = 1'b0;
    exp_row = '0; pend_miss = 1'b0; lat = 3;
    run_line(10, a);
    run_line(11, a);

    for (int k = 0; k < 30; k++) begin
      set_sprite(9'($urandom_range(0, V_TOTAL - 1)), 9'($urandom_range(0, 300)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom),
                 int'($urandom_range(1, 90)), 1'($urandom_range(0, 1)));
      v = (int'(sprite_y) + int'($urandom_range(0, 19)) + V_TOTAL - 2) % V_TOTAL;
      run_line(v, a);
      run_line(wrap_line(v), a);
    end

`ifdef SPRITE_MIRROR_EN
    flip_h = 1'b1;
    set_sprite(9'd30, 9'd40, 3'd7, 2'd1, 16'h8000, 3, 1'b0);
    run_line(29, a);
    run_line(30, a);
    check("mirror_row", {16'd0, exp_row}, 32'h0000_0001);
    set_sprite(9'd30, 9'd40, 3'd7, 2'd1, 16'hC3A1, 6, 1'b0);
    run_line(31, a);
    run_line(32, a);
    flip_h = 1'b0;
    run_line(33, a);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_layer.md
# sprite_layer

Per-sprite layer generator that produces one 3-bit palette index per pixel for the colour priority mixer (the pacman/blinky layer inputs). During horizontal blank it fetches the sprite's next bitmap row from an external sprite ROM over a req/ack handshake and double-buffers it. During the visible line it shifts the row out at the sprite's X position. Output 0 means transparent, so lower-priority layers show through in the mixer.

## Interface
- H_VISIBLE, 256: visible pixels per line; hblank is hpos >= H_VISIBLE.
- H_TOTAL, 341: pixels per line; hpos runs 0..H_TOTAL-1.
- V_TOTAL, 262: lines per frame; vpos runs 0..V_TOTAL-1.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- hpos  in  9  current pixel column from video sync.
- vpos  in  9  current line from video sync.
- sprite_x  in  9  left column of the 16x16 sprite.
- sprite_y  in  9  top line of the sprite.
- sprite_color  in  3  palette index for set bitmap pixels.
- frame  in  2  animation frame select.
- rom_req  out  1  fetch request.
- rom_addr  out  6  {frame, row[3:0]}.
- rom_ack  in  1  ROM handshake acknowledge; rom_data is valid in the same cycle.
- rom_data  in  16  bitmap row; bit 15 is the leftmost pixel.
- color  out  3  layer palette index to the mixer; 0 = transparent.
- fetch_miss  out  1  one-cycle pulse when a fetch is aborted.

## Operation
- Reset values:
  - rom_req=0, rom_addr=0, color=0, fetch_miss=0.
  - Both row buffers are 0.
  - FSM is in IDLE.
- Next line: nl = (vpos==V_TOTAL-1) ? 0 : vpos+1.
- Row select: row = nl - sprite_y, computed as 9-bit unsigned with wrap. The sprite is on the next line iff row < 16.
- FSM states:
  - IDLE: when hpos==H_VISIBLE:
    - if on the next line, latch rom_addr={frame,row[3:0]}, assert rom_req, go to FETCH;
    - else clear the fetch buffer and go to READY.
  - FETCH: hold rom_req and rom_addr stable.
    - On rom_ack=1, capture rom_data into the fetch buffer, drop rom_req the next cycle, go to READY.
    - If hpos==0 occurs first, abort: drop rom_req, clear the fetch buffer, pulse fetch_miss, go to IDLE.
  - READY: on hpos==0, copy the fetch buffer into the active shift register, go to IDLE.
  - On an abort, the active register is also loaded with 0 at hpos==0.
- Shifting:
  - When hpos==sprite_x and hpos < H_VISIBLE, start a 16-pixel run.
  - For each run pixel: color = msb ? sprite_color : 0. Then shift left, filling with 0.
  - Outside a run, or when hpos >= H_VISIBLE, color = 0.
  - A run crossing H_VISIBLE is truncated.
  - If sprite_x >= H_VISIBLE, the sprite is never drawn.
- sprite_x, sprite_y, sprite_color and frame are sampled live. Software changes them only in vblank; a mid-line change affects only later decisions.
- rom_ack while not in FETCH is ignored.
- Reset mid-fetch drops rom_req in the next cycle and forces the reset values above.

## Timing
- Pixel latency: the pixel for column hpos appears on color one clock after hpos is presented (registered output).
- Fetch window: from hpos==H_VISIBLE to hpos==H_TOTAL-1. ROM latency up to H_TOTAL-H_VISIBLE-1 cycles is tolerated.
- rom_req rises the cycle after hpos==H_VISIBLE is sampled.
- rom_req falls the cycle after the ack cycle.
- fetch_miss is high for exactly one cycle, the cycle after hpos==0 is sampled in FETCH.
- The active buffer updates at the hpos==0 clock edge, so there is no tearing within a line.

## Configuration
- SPRITE_MIRROR_EN defined: an extra input flip_h (1 bit) is sampled when rom_ack captures data. When flip_h=1, the 16 bits of rom_data are stored bit-reversed, giving a horizontal mirror.
- SPRITE_MIRROR_EN undefined: there is no flip_h port and rom_data is stored as-is.

## Test plan
- Reset held 3 cycles mid-FETCH -> next cycle rom_req=0, color=0, fetch_miss=0; the following line draws nothing.
- Basic draw: sprite_y=10, sprite_x=100, sprite_color=5, frame=2, ROM returns 16'hF00F two cycles after req on line 9.
  - Check rom_addr=6'b100000.
  - On line 10, color=5 for hpos 100..103 and 112..115 (each seen one clock later); 0 elsewhere.
- Vertical bounds: sprite_y=10, ROM returns row 15 on line 24 hblank.
  - No rom_req during line 25's hblank.
  - color=0 on line 26.
  - vpos wrap: V_TOTAL-1 -> 0 fetches row 0 when sprite_y=0.
- Right edge: sprite_x=250, rom_data=16'hFFFF -> color=sprite_color for hpos 250..255 only, 0 at hpos 256+.
- ROM timeout: rom_ack never asserted -> at hpos==0 fetch_miss pulses once, rom_req drops, the line is fully transparent. A late rom_ack is ignored.
- With SPRITE_MIRROR_EN, flip_h=1, rom_data=16'h8000, sprite_x=40 -> the single set pixel appears at hpos 55, not 40.
